// File: rtl/pc_stack_pkg.sv
// Shared definitions for the program counter / return-address stack.
// The hard-wired controller imports the same command codes.
package pc_stack_pkg;

    // Command codes after priority resolution, one per cycle.
    localparam int CMD_W = 3;
    localparam logic [CMD_W-1:0] CMD_IDLE = 3'd0;
    localparam logic [CMD_W-1:0] CMD_INC  = 3'd1;
    localparam logic [CMD_W-1:0] CMD_LOAD = 3'd2;
    localparam logic [CMD_W-1:0] CMD_CALL = 3'd3;
    localparam logic [CMD_W-1:0] CMD_RET  = 3'd4;
    localparam logic [CMD_W-1:0] CMD_ILL  = 3'd5;

    // Width of a stack pointer that counts 0..depth inclusive.
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of an index into a depth-entry array (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Resolve the raw strobes into a single command: (call&ret), ret, call, lp, cp.
    function automatic logic [CMD_W-1:0] decode_cmd(input logic lp, input logic cp,
                                                    input logic call, input logic ret);
        if (call && ret) return CMD_ILL;
        if (ret)         return CMD_RET;
        if (call)        return CMD_CALL;
        if (lp)          return CMD_LOAD;
        if (cp)          return CMD_INC;
        return CMD_IDLE;
    endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Bus and control bundle between the controller (master) and pc_stack (slave).
interface pc_stack_if
    import pc_stack_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 4
);
    localparam int SPW = sp_width(DEPTH);

    logic [AW-1:0]  bus_in;
    logic [AW-1:0]  bus_out;
    logic           bus_oe;
    logic           lp;
    logic           cp;
    logic           ep;
    logic           call;
    logic           ret;
    logic           err_clr;
    logic [AW-1:0]  pc;
    logic [SPW-1:0] sp;
    logic           full;
    logic           empty;
    logic           ovf;
    logic           unf;

    modport master (
        output bus_in, lp, cp, ep, call, ret, err_clr,
        input  bus_out, bus_oe, pc, sp, full, empty, ovf, unf
    );

    modport slave (
        input  bus_in, lp, cp, ep, call, ret, err_clr,
        output bus_out, bus_oe, pc, sp, full, empty, ovf, unf
    );

endinterface

// File: rtl/pc_stack_ras_lifo.sv
// Return-address stack: register-array LIFO with occupancy count.
// The caller never pushes when full nor pops when empty.
module ras_lifo
    import pc_stack_pkg::*;
#(
    parameter  int AW    = 8,
    parameter  int DEPTH = 4,
    localparam int SPW   = sp_width(DEPTH),
    localparam int IW    = idx_width(DEPTH)
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic           push,
    input  logic           pop,
    input  logic [AW-1:0]  din,
    output logic [AW-1:0]  dout,
    output logic [SPW-1:0] sp,
    output logic           full,
    output logic           empty
);

    logic [AW-1:0]  mem [DEPTH];
    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] sp_m1;

    assign sp_m1 = sp_q - 1'b1;
    assign dout  = mem[sp_m1[IW-1:0]];
    assign sp    = sp_q;
    assign full  = (sp_q == SPW'(DEPTH));
    assign empty = (sp_q == '0);

    // Write the pushed return address into the next free slot.
    // NOTE: the data array has no reset; entries above sp are never read,
    // so clearing them would only cost a reset net per bit.
    always_ff @(posedge clk) begin
        if (push) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            mem[sp_q[IW-1:0]] <= din;
        end
    end

    // Track occupancy; push has priority although the caller never issues both.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sp_q <= '0;
        end else if (push) begin
            sp_q <= sp_q + 1'b1;
        end else if (pop) begin
            sp_q <= sp_m1;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with nested-call return-address stack and sticky
// overflow/underflow flags. Drives the low AW bits of the system bus.
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int            AW      = 8,
    parameter int            DEPTH   = 4,
    parameter logic [AW-1:0] RST_VEC = '0
) (
    input  logic       clk,
    input  logic       clr_n,
    pc_stack_if.slave  bus
);

    logic [CMD_W-1:0] cmd;
    logic [AW-1:0]    pc_q;
    logic [AW-1:0]    pc_nxt;
    logic [AW-1:0]    ras_top;
    logic             ras_full;
    logic             ras_empty;
    logic             push;
    logic             pop;
    logic             set_ovf;
    logic             set_unf;
    logic             ovf_q;
    logic             unf_q;

    assign cmd  = decode_cmd(bus.lp, bus.cp, bus.call, bus.ret);
    assign push = (cmd == CMD_CALL) && !ras_full;
    assign pop  = (cmd == CMD_RET)  && !ras_empty;

    ras_lifo #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk   (clk),
        .clr_n (clr_n),
        .push  (push),
        .pop   (pop),
        .din   (pc_q),
        .dout  (ras_top),
        .sp    (bus.sp),
        .full  (ras_full),
        .empty (ras_empty)
    );

    // Next PC and error events; rejected calls/returns leave the PC alone.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        pc_nxt  = pc_q;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        case (cmd)
            CMD_ILL: begin
                set_ovf = 1'b1;
                set_unf = 1'b1;
            end
            CMD_RET: begin
                if (ras_empty) set_unf = 1'b1;
                else           pc_nxt  = ras_top;
            end
            CMD_CALL: begin
                if (ras_full) set_ovf = 1'b1;
                else          pc_nxt  = bus.bus_in;
            end
            CMD_LOAD: pc_nxt = bus.bus_in;
            CMD_INC:  pc_nxt = pc_q + 1'b1;
            default:  pc_nxt = pc_q;
        endcase
    end

    // PC register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) pc_q <= RST_VEC;
        else        pc_q <= pc_nxt;
    end

    // Sticky error flags; a same-cycle set beats err_clr.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= set_ovf | (ovf_q & ~bus.err_clr);
            unf_q <= set_unf | (unf_q & ~bus.err_clr);
        end
    end

    assign bus.pc      = pc_q;
    assign bus.bus_out = pc_q;
    assign bus.bus_oe  = bus.ep & ~bus.lp & ~bus.call;
    assign bus.full    = ras_full;
    assign bus.empty   = ras_empty;
    assign bus.ovf     = ovf_q;
    assign bus.unf     = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: an AW=8/DEPTH=4 instance and an AW=12/DEPTH=1 instance,
// driven from vector tables plus hand-written reset sequences.
module tb_pc_stack;

    logic clk = 1'b0;
    logic clr_n;

    always #5 clk = ~clk;

    pc_stack_if #(.AW(8),  .DEPTH(4)) ifa ();
    pc_stack_if #(.AW(12), .DEPTH(1)) ifb ();

    pc_stack #(.AW(8), .DEPTH(4), .RST_VEC(8'h00)) dut_a (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (ifa)
    );

    pc_stack #(.AW(12), .DEPTH(1), .RST_VEC(12'h100)) dut_b (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (ifb)
    );

    typedef struct {
        string      name;
        logic       lp, cp, ep, call, ret, err_clr;
        logic [11:0] bus_in;
        logic       oe;       // expected bus_oe before the edge
        logic [11:0] pc;      // expected after the edge
        int         sp;
        logic       ovf, unf;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];
    vec_t sb[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sel      = 0;      // 0: dut_a, 1: dut_b
    int          depth    = 4;
    logic [11:0] prev_pc;

    // ctl bits: lp cp ep call ret err_clr
    function automatic vec_t mk(input string n, input logic [5:0] c, input logic [11:0] b,
                                input logic oe, input logic [11:0] pc, input int sp,
                                input logic ovf, input logic unf);
        vec_t v;
        v.name = n;
        {v.lp, v.cp, v.ep, v.call, v.ret, v.err_clr} = c;
        v.bus_in = b;
        v.oe = oe; v.pc = pc; v.sp = sp; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        if (sel == 0) begin
            ifa.lp = v.lp; ifa.cp = v.cp; ifa.ep = v.ep; ifa.call = v.call;
            ifa.ret = v.ret; ifa.err_clr = v.err_clr; ifa.bus_in = v.bus_in[7:0];
        end else begin
            ifb.lp = v.lp; ifb.cp = v.cp; ifb.ep = v.ep; ifb.call = v.call;
            ifb.ret = v.ret; ifb.err_clr = v.err_clr; ifb.bus_in = v.bus_in;
        end
    endtask

    task automatic sample(output logic [11:0] pc, output logic [11:0] bo, output logic oe,
                          output int sp, output logic full, output logic empty,
                          output logic ovf, output logic unf);
        if (sel == 0) begin
            pc = {4'h0, ifa.pc}; bo = {4'h0, ifa.bus_out}; oe = ifa.bus_oe;
            sp = int'(ifa.sp); full = ifa.full; empty = ifa.empty; ovf = ifa.ovf; unf = ifa.unf;
        end else begin
            pc = ifb.pc; bo = ifb.bus_out; oe = ifb.bus_oe;
            sp = int'(ifb.sp); full = ifb.full; empty = ifb.empty; ovf = ifb.ovf; unf = ifb.unf;
        end
    endtask

    // Check the static state against an expected record (no clock involved).
    task automatic check_state(input string n, input vec_t e);
        logic [11:0] pc, bo;
        logic oe, full, empty, ovf, unf;
        int sp;
        sample(pc, bo, oe, sp, full, empty, ovf, unf);
        check({n, "/pc"},    32'(pc),    32'(e.pc));
        check({n, "/sp"},    32'(sp),    32'(e.sp));
        check({n, "/ovf"},   32'(ovf),   32'(e.ovf));
        check({n, "/unf"},   32'(unf),   32'(e.unf));
        check({n, "/full"},  32'(full),  32'(e.sp == depth));
        check({n, "/empty"}, 32'(empty), 32'(e.sp == 0));
    endtask

    // Drive one vector, check combinational bus outputs, then the registered result.
    task automatic run_vec(input vec_t v);
        logic [11:0] pc, bo;
        logic oe, full, empty, ovf, unf;
        int sp;
        vec_t e;
        drive(v);
        #1;
        sample(pc, bo, oe, sp, full, empty, ovf, unf);
        check({v.name, "/bus_oe"},  32'(oe), 32'(v.oe));
        check({v.name, "/bus_out"}, 32'(bo), 32'(prev_pc));
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_state(e.name, e);
        prev_pc = e.pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        vec_t r;
        idle = mk("idle", 6'b000000, 12'h000, 1'b0, 12'h000, 0, 1'b0, 1'b0);

        //              name            lp cp ep ca rt ec   bus     oe    pc      sp ovf   unf
        tab_a.push_back(mk("inc1",      6'b010000, 12'h000, 1'b0, 12'h001, 0, 1'b0, 1'b0));
        tab_a.push_back(mk("inc2",      6'b010000, 12'h000, 1'b0, 12'h002, 0, 1'b0, 1'b0));
        tab_a.push_back(mk("inc3",      6'b010000, 12'h000, 1'b0, 12'h003, 0, 1'b0, 1'b0));
        tab_a.push_back(mk("ld_ff",     6'b100000, 12'h0FF, 1'b0, 12'h0FF, 0, 1'b0, 1'b0));
        tab_a.push_back(mk("wrap",      6'b010000, 12'h000, 1'b0, 12'h000, 0, 1'b0, 1'b0));
        tab_a.push_back(mk("ld_10",     6'b100000, 12'h010, 1'b0, 12'h010, 0, 1'b0, 1'b0));
        tab_a.push_back(mk("ep_drive",  6'b001000, 12'h000, 1'b1, 12'h010, 0, 1'b0, 1'b0));
        tab_a.push_back(mk("ep_lp",     6'b101000, 12'h040, 1'b0, 12'h040, 0, 1'b0, 1'b0));
        tab_a.push_back(mk("lp_cp",     6'b110000, 12'h004, 1'b0, 12'h004, 0, 1'b0, 1'b0));
        tab_a.push_back(mk("inc4",      6'b010000, 12'h000, 1'b0, 12'h005, 0, 1'b0, 1'b0));
        tab_a.push_back(mk("call1",     6'b001100, 12'h020, 1'b0, 12'h020, 1, 1'b0, 1'b0));
        tab_a.push_back(mk("inc5",      6'b010000, 12'h000, 1'b0, 12'h021, 1, 1'b0, 1'b0));
        tab_a.push_back(mk("inc6",      6'b010000, 12'h000, 1'b0, 12'h022, 1, 1'b0, 1'b0));
        tab_a.push_back(mk("call2",     6'b000100, 12'h030, 1'b0, 12'h030, 2, 1'b0, 1'b0));
        tab_a.push_back(mk("ret1",      6'b001010, 12'h000, 1'b1, 12'h022, 1, 1'b0, 1'b0));
        tab_a.push_back(mk("ret2",      6'b000010, 12'h000, 1'b0, 12'h005, 0, 1'b0, 1'b0));
        tab_a.push_back(mk("ret_unf",   6'b000010, 12'h000, 1'b0, 12'h005, 0, 1'b0, 1'b1));
        tab_a.push_back(mk("cp_unf",    6'b010000, 12'h000, 1'b0, 12'h006, 0, 1'b0, 1'b1));
        tab_a.push_back(mk("clr_unf",   6'b000001, 12'h000, 1'b0, 12'h006, 0, 1'b0, 1'b0));
        tab_a.push_back(mk("set_beats", 6'b000011, 12'h000, 1'b0, 12'h006, 0, 1'b0, 1'b1));
        tab_a.push_back(mk("clr2",      6'b000001, 12'h000, 1'b0, 12'h006, 0, 1'b0, 1'b0));
        tab_a.push_back(mk("fill1",     6'b000100, 12'h080, 1'b0, 12'h080, 1, 1'b0, 1'b0));
        tab_a.push_back(mk("fill2",     6'b000100, 12'h081, 1'b0, 12'h081, 2, 1'b0, 1'b0));
        tab_a.push_back(mk("fill3",     6'b000100, 12'h082, 1'b0, 12'h082, 3, 1'b0, 1'b0));
        tab_a.push_back(mk("fill4",     6'b000100, 12'h083, 1'b0, 12'h083, 4, 1'b0, 1'b0));
        tab_a.push_back(mk("call_ovf",  6'b000100, 12'h084, 1'b0, 12'h083, 4, 1'b1, 1'b0));
        tab_a.push_back(mk("clr_ovf",   6'b000001, 12'h000, 1'b0, 12'h083, 4, 1'b0, 1'b0));
        tab_a.push_back(mk("pop1",      6'b000010, 12'h000, 1'b0, 12'h082, 3, 1'b0, 1'b0));
        tab_a.push_back(mk("pop2",      6'b000010, 12'h000, 1'b0, 12'h081, 2, 1'b0, 1'b0));
        tab_a.push_back(mk("illegal",   6'b000110, 12'h099, 1'b0, 12'h081, 2, 1'b1, 1'b1));
        tab_a.push_back(mk("clr_cp",    6'b010001, 12'h000, 1'b0, 12'h082, 2, 1'b0, 1'b0));
        tab_a.push_back(mk("pop3",      6'b000010, 12'h000, 1'b0, 12'h080, 1, 1'b0, 1'b0));
        tab_a.push_back(mk("pop4",      6'b000010, 12'h000, 1'b0, 12'h006, 0, 1'b0, 1'b0));
        tab_a.push_back(mk("call3",     6'b000100, 12'h070, 1'b0, 12'h070, 1, 1'b0, 1'b0));
        tab_a.push_back(mk("ret_pri",   6'b110010, 12'h011, 1'b0, 12'h006, 0, 1'b0, 1'b0));
        tab_a.push_back(mk("call_pri",  6'b110100, 12'h044, 1'b0, 12'h044, 1, 1'b0, 1'b0));
        tab_a.push_back(mk("ret_pri2",  6'b000010, 12'h000, 1'b0, 12'h006, 0, 1'b0, 1'b0));

        tab_b.push_back(mk("b_inc",     6'b010000, 12'h000, 1'b0, 12'h101, 0, 1'b0, 1'b0));
        tab_b.push_back(mk("b_call",    6'b001100, 12'hABC, 1'b0, 12'hABC, 1, 1'b0, 1'b0));
        tab_b.push_back(mk("b_ovf",     6'b000100, 12'h123, 1'b0, 12'hABC, 1, 1'b1, 1'b0));
        tab_b.push_back(mk("b_cp",      6'b011000, 12'h000, 1'b1, 12'hABD, 1, 1'b1, 1'b0));
        tab_b.push_back(mk("b_ret",     6'b000010, 12'h000, 1'b0, 12'h101, 0, 1'b1, 1'b0));
        tab_b.push_back(mk("b_unf",     6'b000010, 12'h000, 1'b0, 12'h101, 0, 1'b1, 1'b1));
        tab_b.push_back(mk("b_clr",     6'b000001, 12'h000, 1'b0, 12'h101, 0, 1'b0, 1'b0));
        tab_b.push_back(mk("b_ld_fff",  6'b100000, 12'hFFF, 1'b0, 12'hFFF, 0, 1'b0, 1'b0));
        tab_b.push_back(mk("b_wrap",    6'b010000, 12'h000, 1'b0, 12'h000, 0, 1'b0, 1'b0));
        tab_b.push_back(mk("b_illegal", 6'b001110, 12'h055, 1'b0, 12'h000, 0, 1'b1, 1'b1));
        tab_b.push_back(mk("b_call2",   6'b000100, 12'h007, 1'b0, 12'h007, 1, 1'b1, 1'b1));
        tab_b.push_back(mk("b_ret_clr", 6'b000011, 12'h000, 1'b0, 12'h000, 0, 1'b0, 1'b0));

        // Reset state of both instances, no clock edge needed.
        clr_n = 1'b0;
        sel = 0; drive(idle);
        sel = 1; drive(idle);
        #12;
        sel = 0; depth = 4;
        r = idle; r.pc = 12'h000;
        check_state("rst_a", r);
        sel = 1; depth = 1;
        r.pc = 12'h100;
        check_state("rst_b", r);
        clr_n = 1'b1;
        @(posedge clk);
        #1;

        // Instance A: main table.
        sel = 0; depth = 4; prev_pc = 12'h000;
        foreach (tab_a[i]) run_vec(tab_a[i]);

        // Async reset in the middle of a call cycle with a non-empty stack.
        run_vec(mk("pre_rst_call", 6'b000100, 12'h070, 1'b0, 12'h070, 1, 1'b0, 1'b0));
        drive(mk("rst_call", 6'b000100, 12'h055, 1'b0, 12'h000, 0, 1'b0, 1'b0));
        #2;
        clr_n = 1'b0;
        #1;
        r = idle; r.pc = 12'h000;
        check_state("async_rst", r);
        drive(idle);
        #1;
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("post_rst", r);
        prev_pc = 12'h000;
        run_vec(mk("post_rst_ret", 6'b000010, 12'h000, 1'b0, 12'h000, 0, 1'b0, 1'b1));
        drive(idle);

        // Instance B: AW=12, DEPTH=1, RST_VEC=0x100.
        sel = 1; depth = 1;
        clr_n = 1'b0;
        #1;
        r = idle; r.pc = 12'h100;
        check_state("rst_b2", r);
        clr_n = 1'b1;
        prev_pc = 12'h100;
        foreach (tab_b[i]) run_vec(tab_b[i]);
        drive(idle);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter with a hardware return-address stack. Successor to the fixed 8-bit PC plus single subroutine counter and JK select flip-flop.
- Supports nested subroutine calls up to DEPTH levels, with configurable address width and full/empty/overflow/underflow reporting.
- Sits on the low AW bits of the system bus, beside the MAR; the hard-wired controller drives it.

Parameters:
- AW, 8, address / PC width in bits (≥2)
- DEPTH, 4, return-stack entries (≥1)
- RST_VEC, 0, PC value after reset (AW bits)

Ports:
- clk  in  1  system clock, rising-edge active
- clr_n  in  1  asynchronous active-low reset
- bus_in  in  AW  bus value for loads and call targets
- bus_out  out  AW  PC value offered to bus
- bus_oe  out  1  bus drive enable; top level builds the tristate
- lp  in  1  load PC from bus_in (jump)
- cp  in  1  increment PC
- ep  in  1  request to drive PC onto bus
- call  in  1  push PC, then load PC from bus_in
- ret  in  1  pop top of stack into PC
- err_clr  in  1  clear sticky error flags
- pc  out  AW  current PC (registered)
- sp  out  $clog2(DEPTH+1)  number of valid stack entries
- full  out  1  sp == DEPTH
- empty  out  1  sp == 0
- ovf  out  1  sticky: call attempted while full
- unf  out  1  sticky: ret attempted while empty

Behaviour:
- Reset (clr_n low, async): pc=RST_VEC, sp=0, ovf=0, unf=0, stack contents don't-care. All outputs reach reset values immediately, without a clock.
- bus_out = pc combinationally. bus_oe = ep & ~lp & ~call, so the block never drives while loading from the bus.
- All state updates occur on rising clk. The new pc is visible the cycle after the command (1-cycle latency).
- Per-cycle command priority, highest first: (call&ret), ret, call, lp, cp, idle.
- call & ret together: illegal. pc, sp and stack are unchanged; ovf and unf are both set.
- ret, sp>0: pc ← stack[sp-1]; sp ← sp-1.
- ret, sp==0: pc, sp unchanged; unf ← 1.
- call, sp<DEPTH: stack[sp] ← pc; pc ← bus_in; sp ← sp+1.
  - The pushed value is the current pc. The controller asserts call after fetch has incremented pc, so the saved value is the return address.
- call, sp==DEPTH: no push, pc unchanged; ovf ← 1. The call is rejected entirely, never half-executed.
- lp: pc ← bus_in.
- cp: pc ← pc+1 modulo 2^AW; all-ones wraps to 0. The flags ignore wrap.
- lp & cp together: lp wins. Any higher-priority command suppresses cp in the same cycle.
- err_clr: ovf, unf ← 0, unless the same cycle sets them; set beats clear.
- ovf/unf never block later legal commands.
- full and empty are combinational from sp. DEPTH=1 must work: full == ~empty.
- Reset mid-call or mid-return aborts the operation; no partial stack write survives to be observed.

Decomposition:
- Shared package: localparam SPW = $clog2(DEPTH+1) helper function; command-priority encoding constants (CMD_IDLE, CMD_INC, CMD_LOAD, CMD_CALL, CMD_RET, CMD_ILL).
  - The controller reuses these constants.
- One sub-module, ras_lifo (parametrised AW, DEPTH).
  - Register-array LIFO with push/pop, sp, full/empty.
  - No reset on the data array; sp reset only.
- pc_stack holds the pc register, priority decode and sticky flags.

Test Plan:
- Reset/increment: clr_n low, then release; 3×cp → pc=0x03. pc=0xFF, cp → pc=0x00.
- Bus handling: pc=0x10, ep=1 → bus_out=0x10, bus_oe=1. ep=1 with lp=1, bus_in=0x40 → bus_oe=0; next cycle pc=0x40.
- Nested calls: pc=0x05, call bus_in=0x20 → pc=0x20, sp=1. pc=0x22, call bus_in=0x30 → pc=0x30, sp=2. ret → pc=0x22, sp=1. ret → pc=0x05, sp=0, empty=1.
- Overflow (DEPTH=4): five calls → after 4th, full=1. 5th leaves pc and sp=4 unchanged; ovf=1. err_clr → ovf=0.
- Underflow and illegal: ret with sp=0 → pc unchanged, unf=1. call&ret together with sp=2 → pc/sp unchanged, ovf=unf=1.
- Async reset mid-operation: assert clr_n low between edges during a call cycle → pc=RST_VEC, sp=0 before the next edge. Repeat the stack test with AW=12, DEPTH=1.
